pipeline_stall_sequencer: RTL

- Consumer of the hazard detector's stall request in the 5-stage pipelined RISC-V core.
- Combines the stall request with the EX-stage control-flow flush and the ecall halt request, and drives the PC and IF/ID write enables, the IF/ID flush and the ID/EX bubble select.
- Owns the halt-drain state machine, which retires in-flight instructions before asserting is_halted.
- Keeps saturating stall and flush performance counters.

---
 rtl/pipeline_stall_sequencer_if.sv | 28 ++
 rtl/pipeline_stall_sequencer.sv | 107 ++++++++++
 2 files changed

// File: rtl/pipeline_stall_sequencer_if.sv
// Control bundle between the hazard/EX logic and the stall sequencer.
// master drives the requests; slave (the sequencer) drives enables, halt status and counters.
interface pipeline_stall_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             is_stall;
  logic             flush_req;
  logic             halt_req;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             is_halted;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output is_stall, flush_req, halt_req,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
    input  is_halted, stall_count, flush_count
  );

  modport slave (
    input  is_stall, flush_req, halt_req,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble,
    output is_halted, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_stall_sequencer.sv
// Purpose: merges stall/flush/halt requests into PC and pipeline-register controls; owns halt drain.
// Latency: enables are combinational; is_halted rises DRAIN_CYCLES+1 cycles after halt acceptance.
// Backpressure: a stall freezes PC and IF/ID; HALTED freezes the front end until reset.
module pipeline_stall_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  pipeline_stall_sequencer_if.slave    ctl
);

  localparam int DW = ($clog2(DRAIN_CYCLES + 1) < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state_q, state_nxt;
  logic [DW-1:0]    drain_q, drain_nxt;
  logic             halted_q, halted_nxt;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      drain_q     <= '0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q  <= state_nxt;
      drain_q  <= drain_nxt;
      halted_q <= halted_nxt;
      if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_nxt        = state_q;
    drain_nxt        = drain_q;
    halted_nxt       = halted_q;
    stall_inc        = 1'b0;
    flush_inc        = 1'b0;
    ctl.pc_write     = 1'b0;
    ctl.if_id_write  = 1'b0;
    ctl.if_id_flush  = 1'b0;
    ctl.id_ex_bubble = 1'b1;

    if (reset_n) begin
      unique case (state_q)
        RUN: begin
          if (ctl.flush_req) begin
            // The ID instruction is squashed, so any ecall there must not halt.
            ctl.pc_write     = 1'b1;
            ctl.if_id_write  = 1'b1;
            ctl.if_id_flush  = 1'b1;
            ctl.id_ex_bubble = 1'b1;
            flush_inc        = 1'b1;
          end else if (ctl.is_stall) begin
            ctl.id_ex_bubble = 1'b1;
            stall_inc        = 1'b1;
          end else if (ctl.halt_req) begin
            // The ecall moves into EX while fetch stops behind it.
            ctl.if_id_write  = 1'b1;
            ctl.if_id_flush  = 1'b1;
            ctl.id_ex_bubble = 1'b0;
            state_nxt        = DRAIN;
            drain_nxt        = DW'(DRAIN_CYCLES - 1);
          end else begin
            ctl.pc_write     = 1'b1;
            ctl.if_id_write  = 1'b1;
            ctl.id_ex_bubble = 1'b0;
          end
        end
        DRAIN: begin
          ctl.if_id_write  = 1'b1;
          ctl.if_id_flush  = 1'b1;
          ctl.id_ex_bubble = 1'b1;
          if (drain_q == '0) begin
            state_nxt  = HALTED;
            halted_nxt = 1'b1;
          end else begin
            drain_nxt = drain_q - 1'b1;
          end
        end
        HALTED: begin
          ctl.id_ex_bubble = 1'b1;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  assign ctl.is_halted   = halted_q;
  assign ctl.stall_count = stall_cnt_q;
  assign ctl.flush_count = flush_cnt_q;

endmodule
